// File: rtl/pcfx_pad_mapper.sv
// pcfx_pad_mapper: remaps raw joystick words to PC-FX pad words with direction cleanup and mode toggles.
// Optional turbo on I/II is enabled by defining PCFX_PAD_MAPPER_TURBO_EN.
module pcfx_pad_mapper #(
  parameter int NUM_PADS     = 2,
  parameter int TURBO_FRAMES = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [32*NUM_PADS-1:0]   joy_in,
  input  logic                     vsync,
  output logic [16*NUM_PADS-1:0]   pad_out,
  output logic [NUM_PADS-1:0]      pad_changed,
  output logic                     frame_tick
);
  logic r_valid, r_vs, r_tick;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_vs    <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      r_vs    <= vsync;
      r_tick  <= vsync & ~r_vs;
    end
  assign frame_tick = r_tick;
`ifdef PCFX_PAD_MAPPER_TURBO_EN
  logic [3:0] r_cnt;
  logic       r_phase;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_cnt   <= 4'd0;
      r_phase <= 1'b0;
    end else if (r_tick) begin
      r_cnt   <= (r_cnt == 4'(TURBO_FRAMES-1)) ? 4'd0 : r_cnt + 4'd1;
      r_phase <= (r_cnt == 4'(TURBO_FRAMES-1)) ? ~r_phase : r_phase;
    end
`endif
  for (genvar n = 0; n < NUM_PADS; n++) begin : g_pad
    logic [15:0] r_joy, r_pad, w_nxt;
    logic [1:0]  r_prev, r_arm, r_mode, w_mode;
    logic        r_chg, w_ti, w_tii, w_unused_hi;
    assign w_unused_hi = ^joy_in[32*n+16 +: 16];
    // a toggle edge only counts once a 0 has been sampled since reset
    assign w_mode = r_mode ^ (r_joy[15:14] & ~r_prev & r_arm);
`ifdef PCFX_PAD_MAPPER_TURBO_EN
    assign w_ti  = r_joy[12] & ~r_phase;
    assign w_tii = r_joy[13] & ~r_phase;
`else
    logic w_unused_turbo;
    assign w_unused_turbo = ^r_joy[13:12];
    assign w_ti  = 1'b0;
    assign w_tii = 1'b0;
`endif
    assign w_nxt = {2'b00, w_mode,
                    r_joy[1] & ~r_joy[0], r_joy[2] & ~r_joy[3],
                    r_joy[0] & ~r_joy[1], r_joy[3] & ~r_joy[2],
                    r_joy[7], r_joy[6], r_joy[11:8],
                    r_joy[5] & ~w_tii, r_joy[4] & ~w_ti};
    always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
        r_joy  <= 16'd0;
        r_pad  <= 16'd0;
        r_prev <= 2'b00;
        r_arm  <= 2'b00;
        r_mode <= 2'b00;
        r_chg  <= 1'b0;
      end else begin
        r_joy  <= joy_in[32*n +: 16];
        r_prev <= r_joy[15:14];
        r_arm  <= r_arm | ({2{r_valid}} & ~r_joy[15:14]);
        r_mode <= w_mode;
        r_pad  <= w_nxt;
        r_chg  <= w_nxt != r_pad;
      end
    assign pad_out[16*n +: 16] = r_pad;
    assign pad_changed[n]      = r_chg;
  end
endmodule

// File: doc/pcfx_pad_mapper.md
PCFX_PAD_MAPPER -- requirements
Module: pcfx_pad_mapper

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, range 1..8: number of joypad channels.
REQ-002 SHALL have parameter TURBO_FRAMES, default 4, range 1..15: vsync rising edges per turbo phase.
REQ-003 SHALL have port clk_sys, input, 1: sole clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port joy_in, input, 32*NUM_PADS: raw joystick words; pad n occupies bits [32n+31:32n].
REQ-006 SHALL have port vsync, input, 1: video vertical sync, level, same clock domain.
REQ-007 SHALL have port pad_out, output, 16*NUM_PADS: registered pad state; pad n occupies bits [16n+15:16n].
REQ-008 SHALL have port pad_changed, output, NUM_PADS: one-cycle pulse per pad when that pad's pad_out word changes.
REQ-009 SHALL have port frame_tick, output, 1: one-cycle pulse per vsync rising edge.

Function
REQ-010 Joystick word per pad SHALL decode as: [0] right, [1] left, [2] down, [3] up, [4] I, [5] II, [6] select, [7] run, [8] III, [9] IV, [10] V, [11] VI, [12] turbo-I, [13] turbo-II, [14] mode1-toggle, [15] mode2-toggle; bits [31:16] ignored.
REQ-011 pad_out word SHALL be: [0] I, [1] II, [2] III, [3] IV, [4] V, [5] VI, [6] select, [7] run, [8] up, [9] right, [10] down, [11] left, [12] mode1, [13] mode2, [15:14] always 0.
REQ-012 joy_in SHALL be registered once; pad_out SHALL reflect joy_in exactly 2 cycles after joy_in changes (input register + output register).
REQ-013 Opposing directions: up and down both set SHALL output neither; left and right both set SHALL output neither.
REQ-014 mode1 SHALL toggle once on each 0->1 edge of the registered mode1-toggle bit; holding the bit SHALL not retoggle; mode2 likewise with bit [15].
REQ-015 vsync edge detect SHALL use the previous sampled vsync; frame_tick SHALL assert the cycle after vsync is first sampled high, for exactly 1 cycle.
REQ-016 pad_changed[n] SHALL assert in the same cycle pad_out word n takes a new value, and only then.
REQ-017 Channels SHALL be independent; activity on pad n SHALL not affect pad m state.

Reset
REQ-018 reset_n low SHALL immediately clear pad_out, pad_changed, frame_tick, mode1/mode2 latches, input registers, edge-detect registers, turbo counter and turbo phase to 0.
REQ-019 After reset_n deasserts, a toggle bit already held high SHALL not toggle mode; its previous-value register reset to 0 is overridden by requiring one sampled 0 before the first edge counts.
REQ-020 Reset mid-turbo-period SHALL restart the period from count 0, phase 0.

Configuration
REQ-021 With macro PCFX_PAD_MAPPER_TURBO_EN defined: shared 4-bit counter SHALL increment on each frame_tick, and on reaching TURBO_FRAMES-1 SHALL wrap to 0 while phase inverts; if turbo-I is held, output I SHALL be I AND phase; turbo-II likewise for II.
REQ-022 Without PCFX_PAD_MAPPER_TURBO_EN: counter and phase SHALL not exist; turbo bits SHALL be ignored; I and II SHALL pass raw.

Verification
REQ-023 Reset, NUM_PADS=2: joy_in=0x0000_0010 on pad 0 -> pad_out[15:0]=0x0001 two cycles later, pad_changed=2'b01 for 1 cycle, pad 1 stays 0x0000.
REQ-024 Pad 0 joy_in=0x0000_000C (up+down) -> pad_out[15:0]=0x0000; joy_in=0x0000_0009 -> 0x0300.
REQ-025 Pad 1 holds bit [14] for 10 cycles, releases, presses again -> mode1 0->1 after first press, no change while held, 1->0 after second press.
REQ-026 TURBO_EN, TURBO_FRAMES=4: pad 0 joy_in=0x0000_1010, 16 vsync pulses -> bit 0 alternates each 4 frame_ticks: 0,1,0,1 over 4 phases; no frame_tick without vsync edge.
REQ-027 Without TURBO_EN: same stimulus as REQ-026 -> pad_out[0]=1 continuously.
REQ-028 Assert reset_n low mid-turbo at count 2, phase 1 -> all outputs 0 same cycle; after release first phase flip after 4 frame_ticks.
